stopwatch_ctrl: RTL and testbench

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

---
 rtl/stopwatch_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: 0.1 s resolution stopwatch (00.0 .. 59.9) with start/pause and clear
// buttons, driving a multiplexed three-digit active-low seven-segment display.
module stopwatch_ctrl #(
  parameter int TICK_DIV = 500000,
  parameter int SCAN_DIV = 50000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       start_stop,
  input  logic       clear,
  output logic       running,
  output logic       tick,
  output logic [3:0] d_tenths,
  output logic [3:0] d_sec_u,
  output logic [3:0] d_sec_t,
  output logic [2:0] digit_sel,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       e,
  output logic       f,
  output logic       g
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX  = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2} state_t;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'd0:    seg7 = 7'b0000001;
      4'd1:    seg7 = 7'b1001111;
      4'd2:    seg7 = 7'b0010010;
      4'd3:    seg7 = 7'b0000110;
      4'd4:    seg7 = 7'b1001100;
      4'd5:    seg7 = 7'b0100100;
      4'd6:    seg7 = 7'b0100000;
      4'd7:    seg7 = 7'b0001111;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0000100;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  logic [1:0]    ss_sync_r, cl_sync_r, fill_r;
  logic          ss_prev_r, cl_prev_r, ss_armed_r, cl_armed_r;
  logic          start_cmd_s, clear_cmd_s;
  state_t        state_r, state_nx;
  logic [PW-1:0] pre_r, pre_nx;
  logic          tick_r, tick_nx, running_r;
  logic [3:0]    ten_r, secu_r, sect_r, ten_nx, secu_nx, sect_nx, shown_s;
  logic [SW-1:0] scan_r, scan_nx;
  logic [1:0]    idx_r, idx_nx;
  logic [2:0]    dsel_r, dsel_nx;
  logic [6:0]    seg_r;

  // Button synchronizers; a button arms only after a genuine synchronized low is seen.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ss_sync_r  <= 2'b00;
      cl_sync_r  <= 2'b00;
      ss_prev_r  <= 1'b0;
      cl_prev_r  <= 1'b0;
      fill_r     <= 2'd0;
      ss_armed_r <= 1'b0;
      cl_armed_r <= 1'b0;
    end else begin
      ss_sync_r <= {ss_sync_r[0], start_stop};
      cl_sync_r <= {cl_sync_r[0], clear};
      ss_prev_r <= ss_sync_r[1];
      cl_prev_r <= cl_sync_r[1];
      if (fill_r != 2'd2) begin
        fill_r <= fill_r + 2'd1;
      end else begin
        ss_armed_r <= ss_armed_r | ~ss_sync_r[1];
        cl_armed_r <= cl_armed_r | ~cl_sync_r[1];
      end
    end
  end

  assign start_cmd_s = ss_sync_r[1] & ~ss_prev_r & ss_armed_r;
  assign clear_cmd_s = cl_sync_r[1] & ~cl_prev_r & cl_armed_r;

  // FSM state register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // Next state; in PAUSE a simultaneous clear beats start.
  always_comb begin
    state_nx = state_r;
    case (state_r)
      IDLE:    state_nx = start_cmd_s ? RUN : IDLE;
      RUN:     state_nx = start_cmd_s ? PAUSE : RUN;
      PAUSE: begin
        if (clear_cmd_s) begin
          state_nx = IDLE;
        end else if (start_cmd_s) begin
          state_nx = RUN;
        end else begin
          state_nx = PAUSE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Prescaler and BCD counter cascade.
  always_comb begin
    pre_nx  = pre_r;
    tick_nx = 1'b0;
    ten_nx  = ten_r;
    secu_nx = secu_r;
    sect_nx = sect_r;
    if (state_nx == IDLE) begin
      pre_nx  = '0;
      ten_nx  = 4'd0;
      secu_nx = 4'd0;
      sect_nx = 4'd0;
    end else if (state_r == RUN) begin
      if (pre_r == PRE_MAX) begin
        pre_nx  = '0;
        tick_nx = 1'b1;
        if (ten_r == 4'd9) begin
          ten_nx = 4'd0;
          if (secu_r == 4'd9) begin
            secu_nx = 4'd0;
            if (sect_r == 4'd5) begin
              sect_nx = 4'd0;
            end else begin
              sect_nx = sect_r + 4'd1;
            end
          end else begin
            secu_nx = secu_r + 4'd1;
          end
        end else begin
          ten_nx = ten_r + 4'd1;
        end
      end else begin
        pre_nx = pre_r + PW'(1);
      end
    end else begin
      pre_nx = pre_r;
    end
  end

  // Display scan; digit select and segments derive from the same next-index value.
  always_comb begin
    scan_nx = scan_r;
    idx_nx  = idx_r;
    dsel_nx = 3'b110;
    shown_s = ten_nx;
    if (scan_r == SCAN_MAX) begin
      scan_nx = '0;
      case (idx_r)
        2'd0:    idx_nx = 2'd1;
        2'd1:    idx_nx = 2'd2;
        default: idx_nx = 2'd0;
      endcase
    end else begin
      scan_nx = scan_r + SW'(1);
    end
    case (idx_nx)
      2'd1: begin
        dsel_nx = 3'b101;
        shown_s = secu_nx;
      end
      2'd2: begin
        dsel_nx = 3'b011;
        shown_s = sect_nx;
      end
      default: begin
        dsel_nx = 3'b110;
        shown_s = ten_nx;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pre_r     <= '0;
      tick_r    <= 1'b0;
      running_r <= 1'b0;
      ten_r     <= 4'd0;
      secu_r    <= 4'd0;
      sect_r    <= 4'd0;
      scan_r    <= '0;
      idx_r     <= 2'd0;
      dsel_r    <= 3'b110;
      seg_r     <= 7'b0000001;
    end else begin
      pre_r     <= pre_nx;
      tick_r    <= tick_nx;
      running_r <= (state_nx == RUN);
      ten_r     <= ten_nx;
      secu_r    <= secu_nx;
      sect_r    <= sect_nx;
      scan_r    <= scan_nx;
      idx_r     <= idx_nx;
      dsel_r    <= dsel_nx;
      seg_r     <= seg7(shown_s);
    end
  end

  assign running   = running_r;
  assign tick      = tick_r;
  assign d_tenths  = ten_r;
  assign d_sec_u   = secu_r;
  assign d_sec_t   = sect_r;
  assign digit_sel = dsel_r;
  assign {a, b, c, d, e, f, g} = seg_r;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: a running reference model compared every cycle,
// a command table, hand-written timing sequences and random button activity.
module tb_stopwatch_ctrl;

  localparam int TD = 4;
  localparam int SD = 2;
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       start_stop = 1'b0;
  logic       clear = 1'b0;
  logic       running, tick;
  logic [3:0] d_tenths, d_sec_u, d_sec_t;
  logic [2:0] digit_sel;
  logic       a, b, c, d, e, f, g;

  int checks = 0;
  int errors = 0;

  stopwatch_ctrl #(.TICK_DIV(TD), .SCAN_DIV(SD)) dut (
    .clock(clock), .resetn(resetn), .start_stop(start_stop), .clear(clear),
    .running(running), .tick(tick), .d_tenths(d_tenths), .d_sec_u(d_sec_u),
    .d_sec_t(d_sec_t), .digit_sel(digit_sel),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g)
  );

  always #5 clock = ~clock;

  typedef struct { bit s; bit c; bit exp_run; bit exp_zero; } vec_t;
  typedef struct { logic [2:0] sel; logic [6:0] seg; } scan_t;
  vec_t  tbl [10];
  scan_t scan_tbl [3];
  logic [6:0] seg_tab [0:9] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                                7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: elapsed time kept as a count of tenths since clear (0..599).
  int m_mode = M_IDLE, m_pre = 0, m_total = 0, m_scan = 0, m_idx = 0, m_edges = 0, m_next = 0;
  bit m_tick = 1'b0, s_h1 = 1'b0, s_h2 = 1'b0, s_h3 = 1'b0, c_h1 = 1'b0, c_h2 = 1'b0, c_h3 = 1'b0;
  bit m_cs, m_cc;

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      m_mode = M_IDLE; m_pre = 0; m_total = 0; m_scan = 0; m_idx = 0; m_edges = 0; m_tick = 1'b0;
      s_h1 = 1'b0; s_h2 = 1'b0; s_h3 = 1'b0; c_h1 = 1'b0; c_h2 = 1'b0; c_h3 = 1'b0;
    end else begin
      if (m_edges < 100) m_edges = m_edges + 1;
      // a button level that rose two edges ago is the command on this edge
      m_cs = (m_edges >= 4) && s_h2 && !s_h3;
      m_cc = (m_edges >= 4) && c_h2 && !c_h3;
      m_tick = 1'b0;
      if (m_mode == M_RUN) begin
        if (m_pre == TD - 1) begin
          m_pre = 0; m_tick = 1'b1; m_total = (m_total + 1) % 600;
        end else begin
          m_pre = m_pre + 1;
        end
      end
      if (m_mode == M_IDLE)      m_next = m_cs ? M_RUN : M_IDLE;
      else if (m_mode == M_RUN)  m_next = m_cs ? M_PAUSE : M_RUN;
      else                       m_next = m_cc ? M_IDLE : (m_cs ? M_RUN : M_PAUSE);
      if (m_next == M_IDLE) begin
        m_pre = 0; m_total = 0;
      end
      m_mode = m_next;
      if (m_scan == SD - 1) begin
        m_scan = 0; m_idx = (m_idx + 1) % 3;
      end else begin
        m_scan = m_scan + 1;
      end
      s_h3 = s_h2; s_h2 = s_h1; s_h1 = start_stop;
      c_h3 = c_h2; c_h2 = c_h1; c_h1 = clear;
    end
  end

  int         cmp_dig;
  logic [2:0] cmp_sel;

  always @(negedge clock) begin
    cmp_dig = (m_idx == 0) ? (m_total % 10) : ((m_idx == 1) ? ((m_total / 10) % 10) : (m_total / 100));
    cmp_sel = 3'b111 ^ (3'b001 << m_idx);
    chk("model_running", running, (m_mode == M_RUN));
    chk("model_tick", tick, m_tick);
    chk("model_tenths", d_tenths, m_total % 10);
    chk("model_sec_u", d_sec_u, (m_total / 10) % 10);
    chk("model_sec_t", d_sec_t, m_total / 100);
    chk("model_digit_sel", digit_sel, cmp_sel);
    chk("model_segments", {a, b, c, d, e, f, g}, seg_tab[cmp_dig]);
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_running"}, running, 1'b0);
    chk({tag, "_tick"}, tick, 1'b0);
    chk({tag, "_tenths"}, d_tenths, 4'd0);
    chk({tag, "_sec_u"}, d_sec_u, 4'd0);
    chk({tag, "_sec_t"}, d_sec_t, 4'd0);
    chk({tag, "_digit_sel"}, digit_sel, 3'b110);
    chk({tag, "_segments"}, {a, b, c, d, e, f, g}, 7'b0000001);
  endtask

  task automatic do_reset();
    @(negedge clock);
    #1 resetn = 1'b0;
    start_stop = 1'b0;
    clear = 1'b0;
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    repeat (6) @(negedge clock);
  endtask

  task automatic press(input bit s, input bit cl, input int hold);
    @(negedge clock);
    start_stop = s;
    clear = cl;
    repeat (hold) @(negedge clock);
    start_stop = 1'b0;
    clear = 1'b0;
  endtask

  task automatic wait_tick(output int gap);
    gap = 0;
    do begin
      @(negedge clock);
      gap++;
    end while (tick !== 1'b1 && gap < 20);
    if (tick !== 1'b1) chk("tick_timeout", tick, 1'b1);
  endtask

  int ticks, gap, quiet_ticks;

  initial begin
    tbl = '{'{1'b1, 1'b0, 1'b1, 1'b0}, '{1'b0, 1'b1, 1'b1, 1'b0}, '{1'b1, 1'b0, 1'b0, 1'b0},
            '{1'b1, 1'b0, 1'b1, 1'b0}, '{1'b1, 1'b0, 1'b0, 1'b0}, '{1'b0, 1'b1, 1'b0, 1'b1},
            '{1'b0, 1'b1, 1'b0, 1'b1}, '{1'b1, 1'b1, 1'b1, 1'b0}, '{1'b1, 1'b1, 1'b0, 1'b0},
            '{1'b1, 1'b1, 1'b0, 1'b1}};
    scan_tbl = '{'{3'b110, 7'b0000110}, '{3'b101, 7'b0010010}, '{3'b011, 7'b1001111}};

    // reset state and start latency
    repeat (2) @(negedge clock);
    check_reset_vals("reset");
    resetn = 1'b1;
    repeat (6) @(negedge clock);
    start_stop = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clock);
      chk($sformatf("start_edge%0d_running", k), running, (k == 3));
    end
    start_stop = 1'b0;
    ticks = 0;
    while (ticks < 13) begin
      wait_tick(gap);
      ticks++;
      chk($sformatf("tick%0d_period", ticks), gap, TD);
    end
    chk("t13_sec_t", d_sec_t, 4'd0);
    chk("t13_sec_u", d_sec_u, 4'd1);
    chk("t13_tenths", d_tenths, 4'd3);

    // roll-over at 59.9
    while (ticks < 599) begin
      wait_tick(gap);
      ticks++;
    end
    chk("t599_sec_t", d_sec_t, 4'd5);
    chk("t599_sec_u", d_sec_u, 4'd9);
    chk("t599_tenths", d_tenths, 4'd9);
    wait_tick(gap);
    chk("wrap_tick", tick, 1'b1);
    chk("wrap_running", running, 1'b1);
    chk("wrap_digits", {d_sec_t, d_sec_u, d_tenths}, 12'h000);

    // pause with the prescaler at 2, then resume
    repeat (3) @(negedge clock);
    start_stop = 1'b1;
    repeat (2) @(negedge clock);
    chk("pause_before_cmd", running, 1'b1);
    @(negedge clock);
    start_stop = 1'b0;
    chk("pause_running", running, 1'b0);
    chk("pause_digits", {d_sec_t, d_sec_u, d_tenths}, 12'h001);
    quiet_ticks = 0;
    repeat (10) begin
      @(negedge clock);
      if (tick) quiet_ticks++;
    end
    chk("pause_no_tick", quiet_ticks, 0);
    chk("pause_frozen", {d_sec_t, d_sec_u, d_tenths}, 12'h001);
    start_stop = 1'b1;
    repeat (2) @(negedge clock);
    chk("resume_before_cmd", running, 1'b0);
    @(negedge clock);
    start_stop = 1'b0;
    chk("resume_running", running, 1'b1);
    chk("resume_tick_0", tick, 1'b0);
    @(negedge clock);
    chk("resume_tick_1", tick, 1'b0);
    @(negedge clock);
    chk("resume_tick_2", tick, 1'b1);
    chk("resume_tenths", d_tenths, 4'd2);

    // command table
    do_reset();
    for (int i = 0; i < 10; i++) begin
      press(tbl[i].s, tbl[i].c, 4);
      repeat (2) @(negedge clock);
      chk($sformatf("vec%0d_running", i), running, tbl[i].exp_run);
      if (tbl[i].exp_zero) begin
        chk($sformatf("vec%0d_digits", i), {d_sec_t, d_sec_u, d_tenths}, 12'h000);
      end
    end

    // held display of 12.3
    do_reset();
    start_stop = 1'b1;
    ticks = 0;
    while (ticks < 123) begin
      wait_tick(gap);
      ticks++;
      start_stop = 1'b0;
    end
    start_stop = 1'b1;
    repeat (4) @(negedge clock);
    start_stop = 1'b0;
    chk("hold_running", running, 1'b0);
    chk("hold_digits", {d_sec_t, d_sec_u, d_tenths}, 12'h123);
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      chk($sformatf("scan%0d_sel", k), digit_sel, scan_tbl[m_idx].sel);
      chk($sformatf("scan%0d_seg", k), {a, b, c, d, e, f, g}, scan_tbl[m_idx].seg);
    end

    // asynchronous reset between edges while running
    press(1'b1, 1'b0, 3);
    repeat (10) @(negedge clock);
    chk("pre_async_running", running, 1'b1);
    @(posedge clock);
    #2 resetn = 1'b0;
    #1 check_reset_vals("async_reset");
    @(negedge clock);
    resetn = 1'b1;

    // button held through reset release
    @(negedge clock);
    #1 resetn = 1'b0;
    start_stop = 1'b1;
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    repeat (12) @(negedge clock);
    chk("held_through_reset", running, 1'b0);
    start_stop = 1'b0;
    repeat (3) @(negedge clock);
    start_stop = 1'b1;
    repeat (3) @(negedge clock);
    chk("repress_running", running, 1'b1);
    start_stop = 1'b0;

    // random button activity against the model
    do_reset();
    for (int i = 0; i < 250; i++) begin
      press(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), $urandom_range(1, 6));
      repeat ($urandom_range(1, 30)) @(negedge clock);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog expired actual=timeout required=finish");
    $fatal(1);
  end

endmodule
